// File: rtl/exe_issue.sv
// exe_issue: execute-stage issue and capture unit sitting in front of the ALU.
// Accepts one decoded packet per in_valid/in_ready handshake, decodes RV32I OP, OP-IMM, LUI and
// AUIPC into registered ALU operands/op, lets the ALU evaluate on the falling edge, and captures
// the result and flags into a writeback packet held until out_ready.
//
// Ports:
//   clk, rst_n                 clock (ALU uses negedge, this block posedge), async active-low reset
//   in_valid / in_ready        upstream handshake; in_ready only in idle
//   instr, rs1_val, rs2_val    instruction word and register operands
//   pc                         instruction address (AUIPC left operand)
//   alu_lhs, alu_rhs, alu_op   registered ALU operands and op code, stable from accept to accept
//   alu_res, alu_flags         ALU result and flags {zero, sign, carry, overflow}
//   out_valid / out_ready      downstream writeback handshake
//   rd_addr, rd_wdata, rd_we   writeback destination, data and enable
//   out_flags, illegal         captured flags and unsupported-instruction marker
module exe_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] pc,
  output logic [31:0] alu_lhs,
  output logic [31:0] alu_rhs,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        rd_we,
  output logic [3:0]  out_flags,
  output logic        illegal
);

  // ALU op encoding shared with the ALU (mirrors the ALU_*_OP definitions).
  localparam logic [3:0] AluAddOp  = 4'd0;
  localparam logic [3:0] AluSubOp  = 4'd1;
  localparam logic [3:0] AluSllOp  = 4'd2;
  localparam logic [3:0] AluSltOp  = 4'd3;
  localparam logic [3:0] AluSltuOp = 4'd4;
  localparam logic [3:0] AluXorOp  = 4'd5;
  localparam logic [3:0] AluSrlOp  = 4'd6;
  localparam logic [3:0] AluSraOp  = 4'd7;
  localparam logic [3:0] AluOrOp   = 4'd8;
  localparam logic [3:0] AluAndOp  = 4'd9;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0] lhs_q, rhs_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_addr_q;
  logic        illegal_q;
  logic [31:0] rd_wdata_q;
  logic [3:0]  flags_q;
  logic        rd_we_q;

  logic [31:0] dec_lhs, dec_rhs;
  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic        accept;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  // funct3 -> op; alt selects SUB/SRA where the encoding allows it.
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSubOp : AluAddOp;
      3'b001:  op = AluSllOp;
      3'b010:  op = AluSltOp;
      3'b011:  op = AluSltuOp;
      3'b100:  op = AluXorOp;
      3'b101:  op = alt ? AluSraOp : AluSrlOp;
      3'b110:  op = AluOrOp;
      default: op = AluAndOp;
    endcase
    return op;
  endfunction

  always_comb begin
    dec_lhs     = '0;
    dec_rhs     = '0;
    dec_op      = AluAddOp;
    dec_illegal = 1'b0;
    case (opcode)
      OpcOp: begin
        dec_lhs = rs1_val;
        dec_rhs = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, rs2_val[4:0]} : rs2_val;
        dec_op  = f3_to_op(funct3, funct7 == F7Alt);
        if (funct7 == F7Alt) begin
          dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        end else begin
          dec_illegal = (funct7 != F7Base);
        end
      end
      OpcOpImm: begin
        dec_lhs = rs1_val;
        dec_rhs = imm_i;
        // ADDI has no subtract form, so alt only matters for the right shift.
        dec_op  = f3_to_op(funct3, (funct3 == 3'b101) && (funct7 == F7Alt));
        if (funct3 == 3'b001) begin
          dec_rhs     = {27'b0, instr[24:20]};
          dec_illegal = (funct7 != F7Base);
        end else if (funct3 == 3'b101) begin
          dec_rhs     = {27'b0, instr[24:20]};
          dec_illegal = !(funct7 == F7Base || funct7 == F7Alt);
        end
      end
      OpcLui: begin
        dec_lhs = '0;
        dec_rhs = imm_u;
        dec_op  = AluAddOp;
      end
      OpcAuipc: begin
        dec_lhs = pc;
        dec_rhs = imm_u;
        dec_op  = AluAddOp;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal packets still flow through the ALU, but with neutral operands.
    if (dec_illegal) begin
      dec_lhs = '0;
      dec_rhs = '0;
      dec_op  = AluAddOp;
    end
  end

  assign accept = (state_q == StIdle) && in_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lhs_q      <= '0;
      rhs_q      <= '0;
      op_q       <= AluAddOp;
      rd_addr_q  <= '0;
      illegal_q  <= 1'b0;
      rd_wdata_q <= '0;
      flags_q    <= '0;
      rd_we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lhs_q     <= dec_lhs;
        rhs_q     <= dec_rhs;
        op_q      <= dec_op;
        rd_addr_q <= instr[11:7];
        illegal_q <= dec_illegal;
      end
      // ALU has evaluated on the negedge inside EXEC; capture its outputs now.
      if (state_q == StExec) begin
        rd_wdata_q <= illegal_q ? 32'b0 : alu_res;
        flags_q    <= illegal_q ? 4'b0 : alu_flags;
        rd_we_q    <= !illegal_q && (rd_addr_q != 5'd0);
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign alu_lhs   = lhs_q;
  assign alu_rhs   = rhs_q;
  assign alu_op    = op_q;
  assign rd_addr   = rd_addr_q;
  assign rd_wdata  = rd_wdata_q;
  assign rd_we     = rd_we_q;
  assign out_flags = flags_q;
  assign illegal   = illegal_q;

endmodule
